hdmi_timing_ctrl: RTL and testbench



---
 rtl/hdmi_pkg.sv | 47 ++++
 rtl/hdmi_axis_timer.sv | 73 +++++++
 rtl/hdmi_timing_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared definitions for the HDMI video timing path.
//   CNT_W              - width of the horizontal / vertical position counters
//   VGA_800x600_*      - 800x600 timing set (pixels / lines per region)
//   VGA_1024x768_*     - 1024x768 timing set
//   region_e           - region of a scan axis (ACTIVE, FRONT, SYNC, BACK)
//   run_state_e        - frame sequencer state (RUN, IDLE)
//   axis_total()       - total length of one axis from its four region lengths
package hdmi_pkg;

    localparam int CNT_W = 11;

    localparam int unsigned VGA_800x600_HAPIX = 800;
    localparam int unsigned VGA_800x600_HFPOR = 40;
    localparam int unsigned VGA_800x600_HSPUL = 128;
    localparam int unsigned VGA_800x600_HBPOR = 88;
    localparam int unsigned VGA_800x600_VAPIX = 600;
    localparam int unsigned VGA_800x600_VFPOR = 1;
    localparam int unsigned VGA_800x600_VSPUL = 4;
    localparam int unsigned VGA_800x600_VBPOR = 23;

    localparam int unsigned VGA_1024x768_HAPIX = 1024;
    localparam int unsigned VGA_1024x768_HFPOR = 24;
    localparam int unsigned VGA_1024x768_HSPUL = 136;
    localparam int unsigned VGA_1024x768_HBPOR = 160;
    localparam int unsigned VGA_1024x768_VAPIX = 768;
    localparam int unsigned VGA_1024x768_VFPOR = 3;
    localparam int unsigned VGA_1024x768_VSPUL = 6;
    localparam int unsigned VGA_1024x768_VBPOR = 29;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    typedef enum logic {
        RUN  = 1'b0,
        IDLE = 1'b1
    } run_state_e;

    function automatic int unsigned axis_total(input int unsigned a, input int unsigned f,
                                               input int unsigned s, input int unsigned b);
        return a + f + s + b;
    endfunction

endpackage

// File: rtl/hdmi_axis_timer.sv
// hdmi_axis_timer: position counter plus region FSM for one scan axis
// (used once for pixels within a line, once for lines within a frame).
//   clk      - pixel clock
//   srst     - synchronous active-high reset (count 0, region ACTIVE)
//   adv_i    - advance the position by one
//   hold_i   - force the position to 0 / region ACTIVE
//   cnt_o    - current position, 0 .. total-1
//   region_o - region that cnt_o falls in
//   wrap_o   - high on the advancing cycle at position total-1
module hdmi_axis_timer
    import hdmi_pkg::*;
#(
    parameter int unsigned ALEN = 800,
    parameter int unsigned FLEN = 40,
    parameter int unsigned SLEN = 128,
    parameter int unsigned BLEN = 88
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             adv_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o,
    output region_e          region_o,
    output logic             wrap_o
);

    localparam int unsigned TOTAL = axis_total(ALEN, FLEN, SLEN, BLEN);
    // Last position of each region; the FSM steps on these.
    localparam logic [CNT_W-1:0] A_END = CNT_W'(ALEN - 1);
    localparam logic [CNT_W-1:0] F_END = CNT_W'(ALEN + FLEN - 1);
    localparam logic [CNT_W-1:0] S_END = CNT_W'(ALEN + FLEN + SLEN - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    region_e          region_q, region_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q    <= '0;
            region_q <= ACTIVE;
        end else begin
            cnt_q    <= cnt_d;
            region_q <= region_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        region_d = region_q;
        wrap_o   = 1'b0;
        if (hold_i) begin
            cnt_d    = '0;
            region_d = ACTIVE;
        end else if (adv_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (region_q)
                ACTIVE:  if (cnt_q == A_END) region_d = FRONT;
                FRONT:   if (cnt_q == F_END) region_d = SYNC;
                SYNC:    if (cnt_q == S_END) region_d = BACK;
                default: if (cnt_q == LAST)  region_d = ACTIVE;
            endcase
        end
    end

    assign cnt_o    = cnt_q;
    assign region_o = region_q;

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: video timing generator and pixel scheduler.
//   clock_pixel             - pixel clock
//   reset                   - synchronous active-high reset
//   iEnable                 - low: finish the current frame, then idle at frame start
//   iRed/iGreen/iBlue       - source pixel data, qualified by iValid
//   iValid                  - source data valid
//   iClearErr               - clears oUnderflow (a simultaneous new underflow wins)
//   oRequest                - one pixel requested per high cycle
//   oFrameStart             - pulse with the first oRequest of each frame
//   SYNC_H/SYNC_V           - active-low syncs
//   DE                      - data enable, one cycle after oRequest
//   oRed/oGreen/oBlue       - registered pixel data aligned with DE
//   oUnderflow              - sticky: iValid was low for a DE pixel
// Pipeline: stage 0 = counters, stage 1 = request/region decode, stage 2 = DE,
// syncs and pixels. Source data is captured on the edge that closes the
// oRequest cycle, which is the edge that raises DE, so it appears on the
// outputs in the same cycle as DE.
module hdmi_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int unsigned HAPIX = VGA_800x600_HAPIX,
    parameter int unsigned HFPOR = VGA_800x600_HFPOR,
    parameter int unsigned HSPUL = VGA_800x600_HSPUL,
    parameter int unsigned HBPOR = VGA_800x600_HBPOR,
    parameter int unsigned VAPIX = VGA_800x600_VAPIX,
    parameter int unsigned VFPOR = VGA_800x600_VFPOR,
    parameter int unsigned VSPUL = VGA_800x600_VSPUL,
    parameter int unsigned VBPOR = VGA_800x600_VBPOR
) (
    input  logic       clock_pixel,
    input  logic       reset,
    input  logic       iEnable,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    input  logic       iValid,
    input  logic       iClearErr,
    output logic       oRequest,
    output logic       oFrameStart,
    output logic       SYNC_H,
    output logic       SYNC_V,
    output logic       DE,
    output logic [7:0] oRed,
    output logic [7:0] oGreen,
    output logic [7:0] oBlue,
    output logic       oUnderflow
);

    // ---------------- stage 0: run/idle control and counters ----------------
    run_state_e       run_q, run_d;
    logic             run_now;
    logic [CNT_W-1:0] hc, vc;
    region_e          h_region, v_region;
    logic             h_wrap, v_wrap;

    // In IDLE the counters already sit at (0,0), so the first cycle with
    // iEnable high is itself position (0,0) of the new frame.
    assign run_now = (run_q == RUN) || iEnable;

    always_ff @(posedge clock_pixel) begin
        if (reset) run_q <= RUN;
        else       run_q <= run_d;
    end

    always_comb begin
        run_d = run_q;
        if (run_q == RUN) begin
            if (h_wrap && v_wrap && !iEnable) run_d = IDLE;
        end else if (iEnable) begin
            run_d = RUN;
        end
    end

    hdmi_axis_timer #(.ALEN(HAPIX), .FLEN(HFPOR), .SLEN(HSPUL), .BLEN(HBPOR)) u_htimer (
        .clk      (clock_pixel),
        .srst     (reset),
        .adv_i    (run_now),
        .hold_i   (!run_now),
        .cnt_o    (hc),
        .region_o (h_region),
        .wrap_o   (h_wrap)
    );

    hdmi_axis_timer #(.ALEN(VAPIX), .FLEN(VFPOR), .SLEN(VSPUL), .BLEN(VBPOR)) u_vtimer (
        .clk      (clock_pixel),
        .srst     (reset),
        .adv_i    (run_now && h_wrap),
        .hold_i   (!run_now),
        .cnt_o    (vc),
        .region_o (v_region),
        .wrap_o   (v_wrap)
    );

    // ---------------- stage 1: request and region decode ----------------
    logic req_q, req_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        req_d = run_now && (h_region == ACTIVE) && (v_region == ACTIVE);
        fs_d  = run_now && (hc == '0) && (vc == '0);
        hs_d  = run_now && (h_region == SYNC);
        vs_d  = run_now && (v_region == SYNC);
    end

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            req_q <= req_d;
            fs_q  <= fs_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    // ---------------- stage 2: DE, syncs, pixels, underflow ----------------
    logic       de_q, sync_h_q, sync_v_q, uf_q, uf_d;
    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic       pix_ok;

    always_comb begin
        pix_ok  = req_q && iValid;
        red_d   = pix_ok ? iRed   : 8'd0;
        green_d = pix_ok ? iGreen : 8'd0;
        blue_d  = pix_ok ? iBlue  : 8'd0;
        // A new underflow takes priority over a clear on the same cycle.
        uf_d    = uf_q;
        if (req_q && !iValid) uf_d = 1'b1;
        else if (iClearErr)   uf_d = 1'b0;
    end

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            de_q     <= 1'b0;
            sync_h_q <= 1'b1;
            sync_v_q <= 1'b1;
            red_q    <= 8'd0;
            green_q  <= 8'd0;
            blue_q   <= 8'd0;
            uf_q     <= 1'b0;
        end else begin
            de_q     <= req_q;
            sync_h_q <= !hs_q;
            sync_v_q <= !vs_q;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            uf_q     <= uf_d;
        end
    end

    assign oRequest    = req_q;
    assign oFrameStart = fs_q;
    assign DE          = de_q;
    assign SYNC_H      = sync_h_q;
    assign SYNC_V      = sync_v_q;
    assign oRed        = red_q;
    assign oGreen      = green_q;
    assign oBlue       = blue_q;
    assign oUnderflow  = uf_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl with a reduced timing set:
// H 4/1/2/1 (8 cycles per line), V 2/1/1/1 (5 lines), 40 cycles per frame.
// Line layout by position p within the frame: h = p%8, v = p/8;
// active when h<4 and v<2, H sync at h 5..6, V sync on line 3.
// oRequest/oFrameStart reflect position one cycle earlier, DE/syncs/pixels two.
// The source returns pixel value = request index within the frame
// (red = idx, green = ~idx, blue = idx+0x40), presented in the oRequest cycle.
module tb_hdmi_timing_ctrl;

    logic       clk;
    logic       reset, iEnable, iValid, iClearErr;
    logic [7:0] iRed, iGreen, iBlue;
    logic       oRequest, oFrameStart, SYNC_H, SYNC_V, DE, oUnderflow;
    logic [7:0] oRed, oGreen, oBlue;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;
    int t_stop = 1 << 30;
    int ridx  = 0;
    logic exp_uf = 1'b0;

    localparam int BIG = 1 << 30;

    hdmi_timing_ctrl #(
        .HAPIX(4), .HFPOR(1), .HSPUL(2), .HBPOR(1),
        .VAPIX(2), .VFPOR(1), .VSPUL(1), .VBPOR(1)
    ) dut (
        .clock_pixel (clk),
        .reset       (reset),
        .iEnable     (iEnable),
        .iRed        (iRed),
        .iGreen      (iGreen),
        .iBlue       (iBlue),
        .iValid      (iValid),
        .iClearErr   (iClearErr),
        .oRequest    (oRequest),
        .oFrameStart (oFrameStart),
        .SYNC_H      (SYNC_H),
        .SYNC_V      (SYNC_V),
        .DE          (DE),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oUnderflow  (oUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // Frame position of stage-0 cycle s, or -1 while stopped / before start.
    function automatic int pos_of(input int s);
        if (s < t0 || s >= t_stop) return -1;
        return (s - t0) % 40;
    endfunction

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        iValid = 1'b1;
        if (oRequest === 1'b1) begin
            if (oFrameStart === 1'b1) ridx = 0;
            iRed   = 8'(ridx);
            iGreen = ~8'(ridx);
            iBlue  = 8'(ridx + 8'h40);
            ridx++;
        end else begin
            iRed   = 8'hEE;
            iGreen = 8'hEE;
            iBlue  = 8'hEE;
        end
    endtask

    task automatic check_all();
        int p1, p2, idx;
        logic e_req, e_fs, e_de, e_hl, e_vl;
        logic [7:0] er, eg, eb;
        p1 = pos_of(cyc - 1);
        p2 = pos_of(cyc - 2);
        e_req = (p1 >= 0) && (p1 % 8 < 4) && (p1 / 8 < 2);
        e_fs  = (p1 == 0);
        e_de  = (p2 >= 0) && (p2 % 8 < 4) && (p2 / 8 < 2);
        e_hl  = (p2 >= 0) && ((p2 % 8 == 5) || (p2 % 8 == 6));
        e_vl  = (p2 >= 0) && (p2 / 8 == 3);
        idx   = e_de ? (p2 / 8) * 4 + (p2 % 8) : 0;
        er    = e_de ? 8'(idx) : 8'd0;
        eg    = e_de ? ~8'(idx) : 8'd0;
        eb    = e_de ? 8'(idx + 8'h40) : 8'd0;
        chk("oRequest",    32'(oRequest),    32'(e_req));
        chk("oFrameStart", 32'(oFrameStart), 32'(e_fs));
        chk("DE",          32'(DE),          32'(e_de));
        chk("SYNC_H",      32'(SYNC_H),      32'(!e_hl));
        chk("SYNC_V",      32'(SYNC_V),      32'(!e_vl));
        chk("oRed",        32'(oRed),        32'(er));
        chk("oGreen",      32'(oGreen),      32'(eg));
        chk("oBlue",       32'(oBlue),       32'(eb));
        chk("oUnderflow",  32'(oUnderflow),  32'(exp_uf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all();
        end
    endtask

    task automatic wait_level(input string tag, input bit want_req, input bit want_de);
        for (int i = 0; i < 100; i++) begin
            if (want_de  && DE === 1'b1) break;
            if (!want_de && (oRequest === want_req)) break;
            tick();
        end
        if (want_de) chk(tag, 32'(DE), 32'(1));
        else         chk(tag, 32'(oRequest), 32'(want_req));
    endtask

    initial begin
        reset = 1'b1; iEnable = 1'b1; iValid = 1'b1; iClearErr = 1'b0;
        iRed = 8'd0; iGreen = 8'd0; iBlue = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        cyc = 0; t0 = 0; t_stop = BIG;
        check_all();                 // reset state, counters at (0,0)
        run(80);                     // two complete frames

        // iValid low outside a request cycle is ignored
        wait_level("wait_noreq", 1'b0, 1'b0);
        iValid = 1'b0;
        tick();
        chk("uf_ignored", 32'(oUnderflow), 32'(0));

        // single dropped pixel
        wait_level("wait_req", 1'b1, 1'b0);
        iValid = 1'b0;
        tick();
        chk("uf_de",     32'(DE),         32'(1));
        chk("uf_red",    32'(oRed),       32'(0));
        chk("uf_green",  32'(oGreen),     32'(0));
        chk("uf_blue",   32'(oBlue),      32'(0));
        chk("uf_set",    32'(oUnderflow), 32'(1));
        tick();
        tick();
        chk("uf_sticky", 32'(oUnderflow), 32'(1));
        iClearErr = 1'b1;
        tick();
        iClearErr = 1'b0;
        chk("uf_clear",  32'(oUnderflow), 32'(0));

        // set and clear in the same cycle
        wait_level("wait_req2", 1'b1, 1'b0);
        iValid = 1'b0;
        iClearErr = 1'b1;
        tick();
        iClearErr = 1'b0;
        chk("uf_set_wins", 32'(oUnderflow), 32'(1));

        // reset in the middle of an active line
        wait_level("wait_de", 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0; t0 = 0; t_stop = BIG; exp_uf = 1'b0;
        check_all();
        run(20);

        // drop iEnable mid-frame: frame ends at stage-0 position 39
        iEnable = 1'b0;
        t_stop = 40;
        run(40);                     // through cycle 60, idle from 41 on

        // restart: this cycle is position (0,0)
        iEnable = 1'b1;
        t0 = 60; t_stop = BIG;
        run(45);                     // frame starts at cycles 61 and 101

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
